// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant across functional-unit results,
// with a registered one-cycle broadcast of the winner's tag/data to the snoopers.
module cdb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int TAG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          flush_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          cdb_valid_out,
  output logic [TAG_WIDTH-1:0]          cdb_tag_out,
  output logic [DATA_WIDTH-1:0]         cdb_data_out,
  output logic [$clog2(NUM_REQ)-1:0]    cdb_src_out,
  output logic                          err_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NUM_REQ_X = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [IDX_W-1:0]      cdb_src_q, cdb_src_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  transfer;
  logic [IDX_W:0]        scan_idx;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  tag_legal;

  // Grant search starts at rr_ptr and wraps; reset and flush suppress any grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant     = '0;
    grant_idx = '0;
    transfer  = 1'b0;
    scan_idx  = '0;
    if (rst_in && !flush_in) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
        if (scan_idx >= NUM_REQ_X) scan_idx = scan_idx - NUM_REQ_X;
        if (!transfer && req_valid_in[scan_idx[IDX_W-1:0]]) begin
          transfer  = 1'b1;
          grant_idx = scan_idx[IDX_W-1:0];
        end
      end
    end
    if (transfer) grant[grant_idx] = 1'b1;
  end

  assign sel_tag   = req_tag_in[grant_idx*TAG_WIDTH +: TAG_WIDTH];
  assign sel_data  = req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign tag_legal = (sel_tag != '0);

  // Tag 0 means "no producer": accept it to free the unit, but never broadcast it.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    err_d       = err_q;
    if (transfer) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      if (tag_legal) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = sel_tag;
        cdb_data_d  = sel_data;
        cdb_src_d   = grant_idx;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_out = grant;
  assign cdb_valid_out = cdb_valid_q;
  assign cdb_tag_out   = cdb_tag_q;
  assign cdb_data_out  = cdb_data_q;
  assign cdb_src_out   = cdb_src_q;
  assign err_out       = err_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) between the functional units (ALU1, ALU2, later units) that finish in the same cycle, and broadcasts one result per cycle.
- Drives the tag/data that the reservation stations and register status snoop to clear Qj/Qk and capture Vj/Vk.
- Sits between the functional-unit outputs and the reservation-station/register-file update logic.
- Replaces the ad-hoc combinational ALU1/ALU2 result priority with a fair, registered, handshaked broadcast.

Parameters:
- NUM_REQ, 2, number of requesting functional units; range 2..8.
- TAG_WIDTH, 5, producer tag: {station[1:0], row[2:0]}; tag value 0 is reserved for "no producer".
- DATA_WIDTH, 32, result width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- flush_in  input  1  synchronous squash (mispredict recovery).
- req_valid_in  input  NUM_REQ  per-unit result valid.
- req_tag_in  input  NUM_REQ*TAG_WIDTH  per-unit tag; unit i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- req_data_in  input  NUM_REQ*DATA_WIDTH  per-unit result; unit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_out  output  NUM_REQ  grant/accept, one-hot or zero.
- cdb_valid_out  output  1  broadcast valid.
- cdb_tag_out  output  TAG_WIDTH  broadcast tag.
- cdb_data_out  output  DATA_WIDTH  broadcast result.
- cdb_src_out  output  $clog2(NUM_REQ)  index of the granted unit.
- err_out  output  1  sticky illegal-tag flag.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - cdb_valid_out=0, cdb_tag_out=0, cdb_data_out=0, cdb_src_out=0, err_out=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready_out=0 while reset is asserted.
- Grant (combinational, same cycle):
  - Scan units rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first unit with req_valid_in=1 gets req_ready_out=1; all other bits are 0.
  - No valid request gives req_ready_out=0.
  - req_ready_out depends on req_valid_in, but req_valid_in must never depend on req_ready_out.
- Handshake:
  - A transfer occurs on a clock edge where req_valid_in[i] & req_ready_out[i] = 1.
  - A requester holds valid, tag and data stable until accepted. Dropping valid early is a protocol violation; the arbiter ignores it.
- Pointer update: on a transfer from unit i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Broadcast (registered, latency 1):
  - A transfer at edge N sets cdb_valid_out=1, cdb_tag_out, cdb_data_out and cdb_src_out in the cycle after edge N, for exactly one cycle per transfer.
  - Back-to-back transfers produce continuous valid broadcasts, one per cycle.
  - With no transfer, cdb_valid_out <= 0 and tag/data/src hold their last values.
- Illegal tag:
  - A request with tag 0 is still accepted, so the requester never deadlocks, but it is not broadcast: cdb_valid_out stays 0 for that slot.
  - err_out <= 1 and stays set until reset.
  - rr_ptr advances normally.
- Flush (flush_in=1):
  - req_ready_out forced to 0 in that cycle, so no transfer occurs.
  - cdb_valid_out <= 0 at the next edge.
  - rr_ptr holds.
  - Requesters are squashed externally and are expected to drop valid.
- Fairness bound: any continuously valid unit is granted within NUM_REQ cycles, provided flush_in stays 0.
- Simultaneous events:
  - Flush wins over grant.
  - Reset wins over everything.
  - Reset mid-broadcast clears cdb_valid_out immediately (asynchronous).
- Reset release: deassertion is synchronised externally. The first grant is possible in the first cycle after release.

Test Plan:
- Reset then idle: rst_in=0 with random inputs → all outputs 0. After release with no valid requests → req_ready_out=2'b00 and cdb_valid_out=0 every cycle.
- Single requester: unit1 valid, tag 5'h0A, data 32'h0000_1234 → req_ready_out=2'b10 the same cycle. Next cycle cdb_valid_out=1, tag 0x0A, data 0x1234, src=1. Following cycle cdb_valid_out=0.
- Contention fairness: both units valid continuously for 6 cycles with new payloads on each accept → grants 0,1,0,1,0,1. Broadcasts follow one cycle later with matching tag/data/src, and cdb_valid_out stays high throughout.
- Hold under contention: both valid at rr_ptr=1 → unit1 granted. Unit0 holds tag 5'h11, data 32'hDEAD_BEEF and is granted the next cycle. Its broadcast carries exactly 0x11 / 0xDEADBEEF.
- Flush: both valid, flush_in=1 for one cycle → req_ready_out=0 that cycle, cdb_valid_out=0 next cycle, and rr_ptr is unchanged. The grant order resumes correctly afterwards.
- Illegal tag plus async reset:
  - Unit0 valid with tag 0 → accepted, no broadcast, err_out=1 from the next cycle and staying high.
  - Asserting rst_in mid-broadcast → cdb_valid_out and err_out drop to 0 before the next clock edge.
